// File: rtl/stack_pkg.sv
// Shared types and defaults for the two-requester stack arbiter.
package stack_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ILL  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/stack_arbiter_if.sv
// Command/response bundle between the two requesters and the stack arbiter.
interface stack_arbiter_if
  import stack_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [1:0]         req_valid;
  logic [3:0]         req_op;
  logic [2*WIDTH-1:0] req_wdata;
  logic [1:0]         req_ready;
  logic               rsp_valid;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_rdata;
  logic               rsp_err;
  logic [LW-1:0]      level;
  logic               full;
  logic               empty;

  modport master (
    output req_valid, req_op, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, level, full, empty
  );

  modport slave (
    input  req_valid, req_op, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, level, full, empty
  );
endinterface

// File: rtl/stack_mem.sv
// Single-port stack storage: synchronous write, registered read, contents not reset.
module stack_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter/sequencer sharing one LIFO between two requesters.
// Define STACK_ARB_PEEK_EN to enable opcode 11 (peek); otherwise it is rejected as illegal.
//
// state | meaning
// IDLE  | wait for a request, grant one, latch its command
// EXEC  | perform push/pop/peek against the stack memory
// RESP  | present the tagged response for one cycle
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  stack_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_e           state_q, state_d;
  logic             last_q, id_q, grant_id, accept;
  op_e              op_q;
  logic [WIDTH-1:0] wdata_q;
  logic [LW-1:0]    sp_q, sp_d;
  logic [1:0]       ready_d;
  logic             mem_we, mem_re;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             err_d, err_q, rd_d, rd_q;
  logic             is_full, is_empty, peek_ok;

  assign is_full  = (sp_q == LW'(DEPTH));
  assign is_empty = (sp_q == '0);

`ifdef STACK_ARB_PEEK_EN
  assign peek_ok = 1'b1;
`else
  assign peek_ok = 1'b0;
`endif

  // Tie goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    grant_id = 1'b0;
    if (&bus.req_valid)                           grant_id = ~last_q;
    else if (bus.req_valid[1] && !bus.req_valid[0]) grant_id = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = '0;
    accept   = 1'b0;
    sp_d     = sp_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = sp_q[AW-1:0] - AW'(1);
    err_d    = 1'b0;
    rd_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          ready_d[grant_id] = 1'b1;
          accept            = 1'b1;
          state_d           = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
        case (op_q)
          OP_PUSH: begin
            mem_addr = sp_q[AW-1:0];
            if (is_full) err_d = 1'b1;
            else begin
              mem_we = 1'b1;
              sp_d   = sp_q + LW'(1);
            end
          end
          OP_POP: begin
            if (is_empty) err_d = 1'b1;
            else begin
              mem_re = 1'b1;
              rd_d   = 1'b1;
              sp_d   = sp_q - LW'(1);
            end
          end
          OP_PEEK: begin
            if (!peek_ok || is_empty) err_d = 1'b1;
            else begin
              mem_re = 1'b1;
              rd_d   = 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= OP_ILL;
      wdata_q <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      sp_q <= sp_d;
      if (accept) begin
        last_q  <= grant_id;
        id_q    <= grant_id;
        op_q    <= op_e'(grant_id ? bus.req_op[3:2] : bus.req_op[1:0]);
        wdata_q <= grant_id ? bus.req_wdata[2*WIDTH-1:WIDTH] : bus.req_wdata[WIDTH-1:0];
      end
      if (state_q == EXEC) begin
        err_q <= err_d;
        rd_q  <= rd_d;
      end
    end
  end

  stack_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // rd_q masks the unreset RAM output so pushes and errors return zero.
  assign bus.req_ready = ready_d;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rd_q ? mem_rdata : '0;
  assign bus.level     = sp_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: command table plus round-robin, overflow and reset-abort sequences.
module tb_stack_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stack_arbiter_if #(.DEPTH(16), .WIDTH(8)) bus ();

  stack_arbiter #(.DEPTH(16), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [7:0] wdata;
    logic       exp_err;
    logic [7:0] exp_rdata;
    logic [4:0] exp_level;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic id, input logic [1:0] op, input logic [7:0] wdata);
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    if (id) begin
      bus.req_op[3:2]    = op;
      bus.req_wdata[15:8] = wdata;
    end else begin
      bus.req_op[1:0]    = op;
      bus.req_wdata[7:0] = wdata;
    end
  endtask

  task automatic run_cmd(input string tag, input vec_t v);
    int waited;
    logic [1:0] exp_rdy;
    waited = 0;
    exp_rdy = '0;
    exp_rdy[v.id] = 1'b1;
    @(negedge clk);
    drive(v.id, v.op, v.wdata);
    #1;
    while (bus.req_ready == '0 && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk({tag, " ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    @(negedge clk);
    bus.req_valid = '0;
    chk({tag, " no_rsp_in_exec"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, " rsp_id"},    32'(bus.rsp_id),    32'(v.id));
    chk({tag, " rsp_err"},   32'(bus.rsp_err),   32'(v.exp_err));
    chk({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    chk({tag, " level"},     32'(bus.level),     32'(v.exp_level));
    chk({tag, " full"},      32'(bus.full),      32'(v.exp_level == 5'd16));
    chk({tag, " empty"},     32'(bus.empty),     32'(v.exp_level == 5'd0));
  endtask

  initial begin
    int   gid[4];
    int   gcyc[4];
    int   ng;
    logic saw_rsp;
    vec_t v;

    vecs[0]  = '{1'b0, 2'b01, 8'hA5, 1'b0, 8'h00, 5'd1};
    vecs[1]  = '{1'b0, 2'b01, 8'h11, 1'b0, 8'h00, 5'd2};
    vecs[2]  = '{1'b0, 2'b01, 8'h22, 1'b0, 8'h00, 5'd3};
    vecs[3]  = '{1'b1, 2'b10, 8'h00, 1'b0, 8'h22, 5'd2};
    vecs[4]  = '{1'b1, 2'b10, 8'h00, 1'b0, 8'h11, 5'd1};
    vecs[5]  = '{1'b0, 2'b10, 8'h00, 1'b0, 8'hA5, 5'd0};
    vecs[6]  = '{1'b1, 2'b10, 8'h00, 1'b1, 8'h00, 5'd0};
    vecs[7]  = '{1'b0, 2'b00, 8'h5A, 1'b1, 8'h00, 5'd0};
    vecs[8]  = '{1'b0, 2'b01, 8'h3C, 1'b0, 8'h00, 5'd1};
`ifdef STACK_ARB_PEEK_EN
    vecs[9]  = '{1'b1, 2'b11, 8'h00, 1'b0, 8'h3C, 5'd1};
`else
    vecs[9]  = '{1'b1, 2'b11, 8'h00, 1'b1, 8'h00, 5'd1};
`endif
    vecs[10] = '{1'b1, 2'b10, 8'h00, 1'b0, 8'h3C, 5'd0};

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset ready",     32'(bus.req_ready), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("reset rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("reset rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("reset level",     32'(bus.level),     32'd0);
    chk("reset empty",     32'(bus.empty),     32'd1);
    chk("reset full",      32'(bus.full),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // Fill to capacity, overflow once, then confirm LIFO order at the top.
    for (int i = 0; i < 17; i++) begin
      v = '{1'b0, 2'b01, 8'(8'h40 + i), (i == 16), 8'h00, (i == 16) ? 5'd16 : 5'(i + 1)};
      run_cmd($sformatf("fill%0d", i), v);
    end
    run_cmd("pop_top",  '{1'b1, 2'b10, 8'h00, 1'b0, 8'h4F, 5'd15});
    run_cmd("pop_next", '{1'b0, 2'b10, 8'h00, 1'b0, 8'h4E, 5'd14});

    // Both requesters hold push valid: expect 0,1,0,1 with accepts 3 cycles apart.
    reset_dut();
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_op    = 4'b0101;
    bus.req_wdata = 16'hB2B1;
    ng = 0;
    for (int k = 0; k < 20 && ng < 4; k++) begin
      #1;
      if (bus.req_ready != '0) begin
        gid[ng]  = bus.req_ready[1] ? 1 : 0;
        gcyc[ng] = cyc;
        ng++;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    chk("rr grant_count", 32'(ng), 32'd4);
    for (int k = 0; k < 4 && k < ng; k++) chk($sformatf("rr grant%0d", k), 32'(gid[k]), 32'(k % 2));
    for (int k = 1; k < 4 && k < ng; k++) chk($sformatf("rr spacing%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd3);
    @(negedge clk);
    chk("rr rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rr level",     32'(bus.level),     32'd4);

    // Reset during EXEC of a push aborts it with no response.
    reset_dut();
    @(negedge clk);
    drive(1'b0, 2'b01, 8'h99);
    #1;
    chk("abort ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b0;
    saw_rsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    chk("abort no_rsp", 32'(saw_rsp), 32'd0);
    chk("abort level",  32'(bus.level), 32'd0);
    run_cmd("after_abort", '{1'b0, 2'b01, 8'h77, 1'b0, 8'h00, 5'd1});
    run_cmd("after_abort_pop", '{1'b1, 2'b10, 8'h00, 1'b0, 8'h77, 5'd0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
